// File: rtl/aes_round_controller.sv
// AES-128 InvCipher round sequencer driving the decryption state register.
// Optional AES_MIXCOL_PARALLEL_EN: single-cycle InvMixColumns (all columns at once).
module aes_round_controller #(
    parameter int KEYEXP_CYCLES = 10,
    parameter int NR            = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] state_number,
    output logic        mux_enable,
    output logic [1:0]  mux_sel,
    output logic [3:0]  round_key_idx,
    output logic [1:0]  col_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_KEYEXP,
        S_ARK_INIT,
        S_ISR,
        S_ISB,
        S_ARK,
        S_IMC,
        S_DONE
    } state_t;

    localparam logic [7:0] KE_LAST = 8'(KEYEXP_CYCLES - 1);
    localparam logic [3:0] NR_L    = 4'(NR);
    localparam logic [3:0] NR_M1   = 4'(NR - 1);

    localparam logic [1:0] SEL_ARK = 2'd0;
    localparam logic [1:0] SEL_ISR = 2'd1;
    localparam logic [1:0] SEL_ISB = 2'd2;
    localparam logic [1:0] SEL_IMC = 2'd3;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_kcnt;
    logic [7:0] w_kcnt_nxt;
    logic [3:0] r_round;
    logic [3:0] w_round_nxt;
    logic [1:0] r_col;
    logic [1:0] w_col_nxt;
    logic       w_imc_last;

`ifdef AES_MIXCOL_PARALLEL_EN
    assign w_imc_last = 1'b1;
`else
    assign w_imc_last = (r_col == 2'd3);
`endif

    // State and counter registers; reset lands directly in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_kcnt  <= '0;
            r_round <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_kcnt  <= w_kcnt_nxt;
            r_round <= w_round_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Next-state and counter update. r_round is the current round key;
    // it reaches 0 for the final round, whose ARK ends the run.
    always_comb begin
        w_state_nxt = r_state;
        w_kcnt_nxt  = r_kcnt;
        w_round_nxt = r_round;
        w_col_nxt   = r_col;
        unique case (r_state)
            S_IDLE: begin
                w_kcnt_nxt  = '0;
                w_round_nxt = '0;
                w_col_nxt   = '0;
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_KEYEXP;
                w_kcnt_nxt  = '0;
            end
            S_KEYEXP: begin
                if (r_kcnt == KE_LAST) begin
                    w_state_nxt = S_ARK_INIT;
                    w_kcnt_nxt  = '0;
                end else begin
                    w_kcnt_nxt = r_kcnt + 8'd1;
                end
            end
            S_ARK_INIT: begin
                w_state_nxt = S_ISR;
                w_round_nxt = NR_M1;
            end
            S_ISR: begin
                w_state_nxt = S_ISB;
            end
            S_ISB: begin
                w_state_nxt = S_ARK;
            end
            S_ARK: begin
                if (r_round == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IMC;
                    w_col_nxt   = '0;
                end
            end
            S_IMC: begin
                if (w_imc_last) begin
                    w_state_nxt = S_ISR;
                    w_col_nxt   = '0;
                    w_round_nxt = r_round - 4'd1;
                end else begin
                    w_col_nxt = r_col + 2'd1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state and counters.
    always_comb begin
        state_number  = 32'd3;
        mux_enable    = 1'b0;
        mux_sel       = SEL_ARK;
        round_key_idx = 4'd0;
        col_idx       = 2'd0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            S_CLEAR: begin
                state_number = 32'd0;
                busy         = 1'b1;
            end
            S_KEYEXP: begin
                state_number = 32'd1;
                busy         = 1'b1;
            end
            S_ARK_INIT: begin
                state_number  = 32'd2;
                mux_enable    = 1'b1;
                mux_sel       = SEL_ARK;
                round_key_idx = NR_L;
                busy          = 1'b1;
            end
            S_ISR: begin
                state_number  = 32'd2;
                mux_enable    = 1'b1;
                mux_sel       = SEL_ISR;
                round_key_idx = r_round;
                busy          = 1'b1;
            end
            S_ISB: begin
                state_number  = 32'd2;
                mux_enable    = 1'b1;
                mux_sel       = SEL_ISB;
                round_key_idx = r_round;
                busy          = 1'b1;
            end
            S_ARK: begin
                state_number  = 32'd2;
                mux_enable    = 1'b1;
                mux_sel       = SEL_ARK;
                round_key_idx = r_round;
                busy          = 1'b1;
            end
            S_IMC: begin
                state_number  = 32'd2;
                mux_enable    = 1'b1;
                mux_sel       = SEL_IMC;
                round_key_idx = r_round;
                col_idx       = r_col;
                busy          = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_number = 32'd3;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller (default parameters).
// Trace model of the InvCipher schedule plus directed latency/order checks.
module tb_aes_round_controller;

    localparam int KE = 10;
    localparam int NR = 10;
`ifdef AES_MIXCOL_PARALLEL_EN
    localparam int IMC_N   = 1;
    localparam int LAT_LIT = 51;
    localparam int ME_LIT  = 40;
    localparam int IMC_LIT = 9;
`else
    localparam int IMC_N   = 4;
    localparam int LAT_LIT = 78;
    localparam int ME_LIT  = 67;
    localparam int IMC_LIT = 36;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] state_number;
    logic        mux_enable;
    logic [1:0]  mux_sel;
    logic [3:0]  round_key_idx;
    logic [1:0]  col_idx;
    logic        busy;
    logic        done;

    aes_round_controller #(
        .KEYEXP_CYCLES(KE),
        .NR(NR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .state_number(state_number),
        .mux_enable(mux_enable),
        .mux_sel(mux_sel),
        .round_key_idx(round_key_idx),
        .col_idx(col_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sn;
        logic        me;
        logic [1:0]  sel;
        logic [3:0]  rk;
        logic [1:0]  col;
        logic        bz;
        logic        dn;
    } out_t;

    out_t trace[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_phase = 0;
    int   m_t = 0;

    function automatic out_t mk(int sn, int me, int sel, int rk, int col, int bz, int dn);
        out_t o;
        o.sn  = sn;
        o.me  = me[0];
        o.sel = sel[1:0];
        o.rk  = rk[3:0];
        o.col = col[1:0];
        o.bz  = bz[0];
        o.dn  = dn[0];
        return o;
    endfunction

    // Expected per-cycle outputs of one run, listed operation by operation.
    function automatic void build();
        trace.delete();
        trace.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < KE; i++) trace.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        trace.push_back(mk(2, 1, 0, NR, 0, 1, 0));
        for (int r = NR - 1; r >= 1; r--) begin
            trace.push_back(mk(2, 1, 1, r, 0, 1, 0));
            trace.push_back(mk(2, 1, 2, r, 0, 1, 0));
            trace.push_back(mk(2, 1, 0, r, 0, 1, 0));
            for (int c = 0; c < IMC_N; c++) trace.push_back(mk(2, 1, 3, r, c, 1, 0));
        end
        trace.push_back(mk(2, 1, 1, 0, 0, 1, 0));
        trace.push_back(mk(2, 1, 2, 0, 0, 1, 0));
        trace.push_back(mk(2, 1, 0, 0, 0, 1, 0));
    endfunction

    function automatic out_t expected();
        if (m_phase == 1) return trace[m_t];
        return mk(3, 0, 0, 0, 0, 0, (m_phase == 2) ? 1 : 0);
    endfunction

    // Model: 0 idle, 1 running through trace, 2 holding result.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_t     <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase <= 1; m_t <= 0; end
                1: if (m_t == trace.size() - 1) m_phase <= 2;
                   else m_t <= m_t + 1;
                default: if (!start) m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        out_t a;
        out_t e;
        a = {state_number, mux_enable, mux_sel, round_key_idx, col_idx, busy, done};
        e = expected();
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, a, e);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int lat, me_cnt, imc_cnt, col_bad, n0, n1, n2;
    int arks[$];
    int last_sel, last_rk;

    // mode 0: one-cycle start pulse, 1: start held, 2: start toggled
    task automatic run(input int mode);
        lat = -1; me_cnt = 0; imc_cnt = 0; col_bad = 0;
        n0 = 0; n1 = 0; n2 = 0; arks.delete();
        last_sel = -1; last_rk = -1;
        @(negedge clk);
        #1 start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (state_number == 0) n0++;
            if (state_number == 1) n1++;
            if (state_number == 2) n2++;
            if (mux_enable) begin
                me_cnt++;
                last_sel = int'(mux_sel);
                last_rk  = int'(round_key_idx);
                if (mux_sel == 2'd0) arks.push_back(int'(round_key_idx));
                if (mux_sel == 2'd3) begin
                    if (int'(col_idx) != imc_cnt % IMC_N) col_bad++;
                    imc_cnt++;
                end
            end
            #1;
            if (mode == 0) start = 1'b0;
            else if (mode == 2) start = (k % 3 == 0) || (k > 30 && k < 36);
            @(negedge clk);
        end
        chk("run_bounded", (lat >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        build();
        chk("model_len", trace.size(), LAT_LIT);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state_number", int'(state_number), 3);
        chk("rst_busy_done", int'({busy, done, mux_enable}), 0);
        #1 reset = 1'b0;

        run(0);
        chk("latency_pulse", lat, LAT_LIT);
        chk("mux_enable_cycles", me_cnt, ME_LIT);
        chk("sn0_cycles", n0, 1);
        chk("sn1_cycles", n1, KE);
        chk("sn2_cycles", n2, ME_LIT);
        chk("imc_cycles", imc_cnt, IMC_LIT);
        chk("imc_col_order", col_bad, 0);
        chk("ark_count", arks.size(), 11);
        for (int i = 0; i < arks.size(); i++) chk("ark_key_idx", arks[i], 10 - i);
        chk("last_op_sel", last_sel, 0);
        chk("last_op_rk", last_rk, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        run(2);
        chk("latency_toggle", lat, LAT_LIT);
        chk("mux_enable_toggle", me_cnt, ME_LIT);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);

        run(1);
        chk("latency_hold", lat, LAT_LIT);
        repeat (3) @(negedge clk);
        chk("hold_done", int'(done), 1);
        chk("hold_sn", int'(state_number), 3);
        #1 start = 1'b0;
        @(negedge clk);
        chk("idle_done", int'(done), 0);
        chk("idle_sn", int'(state_number), 3);
        #1 start = 1'b1;
        @(negedge clk);
        chk("restart_clear_sn", int'(state_number), 0);
        chk("restart_busy", int'(busy), 1);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("keyexp_sn", int'(state_number), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_sn", int'(state_number), 3);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_me", int'(mux_enable), 0);
        @(negedge clk);
        #1 reset = 1'b0;

        run(0);
        chk("latency_after_rst", lat, LAT_LIT);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
